dsp_chain_sop_accum: RTL and testbench

Result-side consumer for the integer sum-of-products DSP cascade: it takes the 37-bit signed result from the last stage of the chain and accumulates a programmable number of beats into one wide dot-product value. Each completed dot product is pushed into a small output FIFO and presented on a valid/ready interface. It sits directly after the final chain stage and before the downstream writeback or stream logic.

---
 rtl/dsp_chain_sop_accum.sv | 120 ++++++++++++
 tb/tb_dsp_chain_sop_accum.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_chain_sop_accum.sv
// Sum-of-products chain result accumulator.
// Groups cfg_len beats into one dot product and queues it in a small FIFO.
module dsp_chain_sop_accum #(
  parameter int DATA_W     = 37,
  parameter int ACC_W      = 48,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic signed [ACC_W-1:0] acc;
  logic [LEN_W-1:0]        beat_cnt;
  logic [LEN_W-1:0]        len_q;

  logic signed [ACC_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wptr;
  logic [PW-1:0]           rptr;
  logic [CW-1:0]           count;

  logic                    first;
  logic [LEN_W-1:0]        cfg_eff;
  logic [LEN_W-1:0]        eff_len;
  logic                    last;
  logic signed [ACC_W-1:0] acc_op;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    sum_ovf;
  logic                    accept;
  logic                    take;
  logic                    push;
  logic                    pop;
  logic                    full;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];
  assign busy      = (beat_cnt != '0);

  assign first   = (beat_cnt == '0);
  assign cfg_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign eff_len = first ? cfg_eff : len_q;
  assign last    = (beat_cnt == eff_len - LEN_W'(1));

  assign acc_op  = first ? '0 : acc;
  assign in_ext  = ACC_W'(in_data);
  assign sum     = acc_op + in_ext;
  assign sum_ovf = (acc_op[ACC_W-1] == in_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_op[ACC_W-1]);

  assign accept = in_valid && in_ready;
  // a flushed beat is dropped entirely, including its overflow
  assign take   = accept && !flush;
  assign push   = take && last;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      beat_cnt <= '0;
      len_q    <= LEN_W'(1);
      ovf      <= 1'b0;
    end else begin
      if (flush) begin
        acc      <= '0;
        beat_cnt <= '0;
      end else if (accept) begin
        if (first)
          len_q <= cfg_eff;
        if (last) begin
          acc      <= '0;
          beat_cnt <= '0;
        end else begin
          acc      <= sum;
          beat_cnt <= beat_cnt + LEN_W'(1);
        end
      end
      if (take && sum_ovf)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= sum;
        wptr      <= wptr + PW'(1);
      end
      if (pop)
        rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_chain_sop_accum.sv
// Directed bench for dsp_chain_sop_accum.
// LEN_W widened so one group can push the 48-bit accumulator past its range.
module tb_dsp_chain_sop_accum;

  localparam int DATA_W = 37;
  localparam int ACC_W  = 48;
  localparam int LEN_W  = 12;
  localparam int DEPTH  = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [LEN_W-1:0]         cfg_len = '0;
  logic                     flush = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     in_ready;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_ready = 1'b0;
  logic                     busy;
  logic                     ovf;

  int n_cmp = 0;
  int n_bad = 0;

  dsp_chain_sop_accum #(
    .DATA_W(DATA_W),
    .ACC_W(ACC_W),
    .LEN_W(LEN_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_len(cfg_len),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input longint d);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_exp(input string tag, input longint exp);
    chk({tag, "_valid"}, longint'(out_valid), 1);
    chk({tag, "_data"}, longint'(out_data), exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  longint m;
  longint wrapv;
  int     nxt;
  int     rcv;
  logic   a;
  logic   p;
  longint d;

  initial begin
    m     = (longint'(1) <<< 36) - 1;
    wrapv = -(longint'(1) <<< 47) + (longint'(1) <<< 36) - 2049;

    tick();
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ovf", longint'(ovf), 0);
    reset = 1'b1;
    tick();

    // reset mid-group, no clock edge needed
    cfg_len = 3;
    beat(1);
    beat(2);
    chk("mid_busy", longint'(busy), 1);
    reset = 1'b0;
    #1;
    chk("async_busy", longint'(busy), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rel_in_ready", longint'(in_ready), 1);
    chk("rel_out_valid", longint'(out_valid), 0);
    chk("rel_busy", longint'(busy), 0);
    chk("rel_ovf", longint'(ovf), 0);

    // dot product 5 - 2 + 10
    cfg_len = 3;
    beat(5);
    chk("dp_busy1", longint'(busy), 1);
    chk("dp_nv1", longint'(out_valid), 0);
    beat(-2);
    chk("dp_busy2", longint'(busy), 1);
    chk("dp_nv2", longint'(out_valid), 0);
    beat(10);
    chk("dp_busy3", longint'(busy), 0);
    pop_exp("dp", 13);
    chk("dp_once", longint'(out_valid), 0);

    // length 0 acts as 1
    cfg_len = 0;
    beat(7);
    chk("l0_first", longint'(out_data), 7);
    beat(-7);
    pop_exp("l0_a", 7);
    pop_exp("l0_b", -7);

    // cfg_len change mid-group is ignored
    cfg_len = 2;
    beat(4);
    cfg_len = 5;
    beat(6);
    chk("mg_busy", longint'(busy), 0);
    pop_exp("mg", 10);

    // backpressure with wrap
    cfg_len = 1;
    nxt = 1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (nxt <= 6);
      in_data  = DATA_W'(nxt);
      a = in_ready;
      tick();
      if (a && in_valid) nxt++;
    end
    in_valid = 1'b0;
    chk("bp_accepts", nxt, 5);
    chk("bp_in_ready", longint'(in_ready), 0);
    out_ready = 1'b1;
    rcv = 1;
    for (int c = 0; c < 40 && rcv <= 6; c++) begin
      in_valid = (nxt <= 6);
      in_data  = DATA_W'(nxt);
      a = in_ready && in_valid;
      p = out_valid;
      d = longint'(out_data);
      if (p) chk("bp_data", d, rcv);
      tick();
      if (a) nxt++;
      if (p) rcv++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_rcv", rcv, 7);
    chk("bp_sent", nxt, 7);
    chk("bp_empty", longint'(out_valid), 0);

    // flush drops partial sum and the coincident beat
    cfg_len = 4;
    beat(100);
    beat(200);
    flush = 1'b1;
    beat(300);
    flush = 1'b0;
    chk("fl_busy", longint'(busy), 0);
    chk("fl_nv", longint'(out_valid), 0);
    beat(1);
    beat(2);
    beat(3);
    beat(4);
    pop_exp("fl", 10);
    chk("fl_ovf", longint'(ovf), 0);
    chk("fl_empty", longint'(out_valid), 0);

    // large beats without overflow
    cfg_len = 2;
    for (int g = 0; g < 2; g++) begin
      beat(m);
      beat(m);
      pop_exp("big", 2 * m);
    end
    chk("big_ovf", longint'(ovf), 0);

    // one group crossing 2^47-1
    cfg_len = 2049;
    for (int i = 0; i < 2048; i++) beat(m);
    chk("ov_busy", longint'(busy), 1);
    chk("ov_pre", longint'(ovf), 0);
    beat(m);
    chk("ov_set", longint'(ovf), 1);
    pop_exp("ov", wrapv);
    cfg_len = 1;
    beat(3);
    pop_exp("ov_after", 3);
    chk("ov_sticky", longint'(ovf), 1);
    reset = 1'b0;
    #1;
    chk("ov_clr", longint'(ovf), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("ov_rdy", longint'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
